// File: rtl/conv3d_window_mac_stream.sv
// conv3d_window_mac_stream: streaming 3D-convolution window MAC, one (act, wgt) tap per cycle,
// one saturated sum per KD*KH*KW*CIN taps. Define CONV3D_BIAS_EN to add a per-window bias_in seed.
module conv3d_window_mac_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned KD     = 2,
  parameter int unsigned KH     = 3,
  parameter int unsigned KW     = 3,
  parameter int unsigned CIN    = 2,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_act,
  input  logic [DATA_W-1:0]                   in_wgt,
`ifdef CONV3D_BIAS_EN
  input  logic [OUT_W-1:0]                    bias_in,
`endif
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_W-1:0]                    out_data,
  output logic                                out_sat,
  output logic [$clog2(KD*KH*KW*CIN)-1:0]     tap_idx
);

  localparam int unsigned TAPS   = KD * KH * KW * CIN;
  localparam int unsigned IDX_W  = $clog2(TAPS);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic                     live;
  logic                     stall_c;
  logic                     accept_c;
  logic                     first_c;
  logic                     last_c;
  logic signed [PROD_W-1:0] prod_c;

  logic                     p_valid;
  logic                     p_first;
  logic                     p_last;
  logic signed [PROD_W-1:0] p_prod;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_seed_c;
  logic signed [ACC_W-1:0]  acc_next_c;
  logic [OUT_W-1:0]         sat_data_c;
  logic                     sat_flag_c;

  // Handshake: the whole pipeline freezes while a finished result waits downstream.
  assign stall_c  = out_valid && !out_ready;
  assign in_ready = live && !stall_c;
  assign accept_c = in_valid && in_ready;
  assign first_c  = (tap_idx == '0);
  assign last_c   = (tap_idx == IDX_W'(TAPS - 1));
  assign prod_c   = PROD_W'($signed(in_act)) * PROD_W'($signed(in_wgt));

`ifdef CONV3D_BIAS_EN
  logic signed [OUT_W-1:0] p_bias;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_bias <= '0;
    end else if (accept_c && first_c) begin
      p_bias <= $signed(bias_in);
    end
  end

  assign acc_seed_c = ACC_W'(p_bias);
`else
  assign acc_seed_c = '0;
`endif

  assign acc_next_c = (p_first ? acc_seed_c : acc) + ACC_W'(p_prod);

  // Clamp the window sum into the signed output range.
  always_comb begin
    sat_data_c = OUT_W'(acc_next_c);
    sat_flag_c = 1'b0;
    if (acc_next_c > SAT_MAX) begin
      sat_data_c = OUT_W'(SAT_MAX);
      sat_flag_c = 1'b1;
    end else if (acc_next_c < SAT_MIN) begin
      sat_data_c = OUT_W'(SAT_MIN);
      sat_flag_c = 1'b1;
    end
  end

  // in_ready comes up on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_idx <= '0;
    end else if (accept_c) begin
      tap_idx <= last_c ? '0 : tap_idx + IDX_W'(1);
    end
  end

  // Stage 1: full-precision product tagged with window position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      p_prod  <= '0;
    end else if (!stall_c) begin
      p_valid <= accept_c;
      p_first <= first_c;
      p_last  <= last_c;
      p_prod  <= prod_c;
    end
  end

  // Stage 2: accumulator, restarted by the first-tap tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (!stall_c && p_valid) begin
      acc <= acc_next_c;
    end
  end

  // Output register: a new result may load in the same cycle the old one is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall_c && p_valid && p_last) begin
      out_valid <= 1'b1;
      out_data  <= sat_data_c;
      out_sat   <= sat_flag_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3d_window_mac_stream.sv
// Bench for conv3d_window_mac_stream: window-sum queue model checked every cycle plus directed literals.
// Build with CONV3D_BIAS_EN defined to also exercise the bias seed.
module tb_conv3d_window_mac_stream;

  localparam int TAPS = 36;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_act;
  logic [7:0]  in_wgt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [5:0]  tap_idx;
`ifdef CONV3D_BIAS_EN
  logic [15:0] bias_in;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int age = 0;

  typedef struct {
    int val;
    bit sat;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   got_q[$];
  bit   got_sat_q[$];
  int   sum_m = 0;
  int   idx_m = 0;

  conv3d_window_mac_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
`ifdef CONV3D_BIAS_EN
    .bias_in   (bias_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .tap_idx   (tap_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) age = 0;
    else if (age < 2) age++;
  end

  task automatic check(input string name, input longint got_v, input longint exp_v);
    checks++;
    if (got_v != exp_v) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got_v, exp_v, $time);
    end
  endtask

  // Reference model: sum of accepted taps per window, saturated, due two cycles after the last tap.
  always @(negedge clk) begin
    bit   due_now;
    exp_t e;
    int   bias_v;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_tap_idx", tap_idx, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sat", out_sat, 0);
      exp_q.delete();
      sum_m = 0;
      idx_m = 0;
    end else begin
      due_now = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      check("cmp_out_valid", out_valid, due_now);
      if (out_valid && exp_q.size() > 0) begin
        check("cmp_out_data", $signed(out_data), exp_q[0].val);
        check("cmp_out_sat", out_sat, exp_q[0].sat);
      end
      check("cmp_tap_idx", tap_idx, idx_m);
      if (age >= 1) check("cmp_in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got_q.push_back(int'($signed(out_data)));
        got_sat_q.push_back(out_sat);
      end
      if (in_valid && in_ready) begin
        if (idx_m == 0) begin
`ifdef CONV3D_BIAS_EN
          bias_v = int'($signed(bias_in));
`else
          bias_v = 0;
`endif
          sum_m = bias_v;
        end
        sum_m += int'($signed(in_act)) * int'($signed(in_wgt));
        if (idx_m == TAPS - 1) begin
          if (sum_m > 32767) begin
            e.val = 32767; e.sat = 1'b1;
          end else if (sum_m < -32768) begin
            e.val = -32768; e.sat = 1'b1;
          end else begin
            e.val = sum_m; e.sat = 1'b0;
          end
          e.due = cyc + 2;
          exp_q.push_back(e);
          idx_m = 0;
        end else begin
          idx_m++;
        end
      end
    end
  end

  task automatic send_tap(input logic signed [7:0] a, input logic signed [7:0] w);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_act   = a;
    in_wgt   = w;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 300);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready stuck low, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic signed [7:0] a, input logic signed [7:0] w);
    for (int i = 0; i < n; i++) send_tap(a, w);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_got(input string name, input int k, input int val, input bit sat);
    if (got_q.size() > k) begin
      check({name, "_data"}, got_q[k], val);
      check({name, "_sat"}, got_sat_q[k], sat);
    end else begin
      check({name, "_count"}, got_q.size(), k + 1);
    end
  endtask

  task automatic clear_got();
    got_q.delete();
    got_sat_q.delete();
  endtask

  initial begin
    int c0;
    in_valid  = 1'b0;
    in_act    = '0;
    in_wgt    = '0;
    out_ready = 1'b1;
`ifdef CONV3D_BIAS_EN
    bias_in   = '0;
`endif
    #12;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", in_ready, 1);

    // T1: unit taps, latency two cycles after the last accept
    clear_got();
    send_n(TAPS, 8'sd1, 8'sd1);
    @(negedge clk);
    check("t1_valid_t1", out_valid, 0);
    @(negedge clk);
    check("t1_valid_t2", out_valid, 1);
    check("t1_data_t2", $signed(out_data), 36);
    drain();
    check_got("t1", 0, 36, 1'b0);

    // T2: saturation both directions
    clear_got();
    send_n(TAPS, 8'sd127, 8'sd127);
    send_n(TAPS, -8'sd128, 8'sd127);
    drain();
    check_got("t2_pos", 0, 32767, 1'b1);
    check_got("t2_neg", 1, -32768, 1'b1);

    // T7: exact saturation boundaries
    clear_got();
    send_n(2, 8'sd127, 8'sd127); send_tap(8'sd127, 8'sd4); send_tap(8'sd1, 8'sd1); send_n(32, 8'sd0, 8'sd0);
    send_n(2, 8'sd127, 8'sd127); send_tap(8'sd127, 8'sd4); send_tap(8'sd1, 8'sd2); send_n(32, 8'sd0, 8'sd0);
    send_n(2, -8'sd128, 8'sd127); send_tap(-8'sd128, 8'sd2); send_n(33, 8'sd0, 8'sd0);
    send_n(2, -8'sd128, 8'sd127); send_tap(-8'sd128, 8'sd2); send_tap(-8'sd1, 8'sd1); send_n(32, 8'sd0, 8'sd0);
    drain();
    check_got("t7_max_exact", 0, 32767, 1'b0);
    check_got("t7_max_over", 1, 32767, 1'b1);
    check_got("t7_min_exact", 2, -32768, 1'b0);
    check_got("t7_min_under", 3, -32768, 1'b1);

    // T3: downstream stall after the first result
    clear_got();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 300 && !out_valid; i++) @(negedge clk);
        check("t3_stall_in_ready", in_ready, 0);
        check("t3_stall_tap_idx", tap_idx, 1);
        repeat (5) @(posedge clk);
        #1;
        check("t3_frozen_tap_idx", tap_idx, 1);
        check("t3_frozen_in_ready", in_ready, 0);
        check("t3_held_data", $signed(out_data), 36);
        out_ready = 1'b1;
      end
    join_none
    send_n(TAPS, 8'sd1, 8'sd1);
    send_n(TAPS, 8'sd2, 8'sd1);
    drain();
    check_got("t3_first", 0, 36, 1'b0);
    check_got("t3_second", 1, 72, 1'b0);
    check("t3_count", got_q.size(), 2);

    // T4: reset mid-window discards the partial sum
    clear_got();
    out_ready = 1'b1;
    send_n(10, 8'sd1, 8'sd1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_out_valid", out_valid, 0);
    check("t4_async_tap_idx", tap_idx, 0);
    check("t4_async_in_ready", in_ready, 0);
    check("t4_async_out_data", out_data, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_n(TAPS, 8'sd1, 8'sd1);
    drain();
    check_got("t4_after_reset", 0, 36, 1'b0);
    check("t4_count", got_q.size(), 1);

`ifdef CONV3D_BIAS_EN
    // T5: bias sampled on tap 0 only
    clear_got();
    bias_in = -16'sd5;
    send_tap(8'sd1, 8'sd1);
    bias_in = 16'sd100;
    send_n(TAPS - 1, 8'sd1, 8'sd1);
    drain();
    check_got("t5_bias", 0, 31, 1'b0);
    bias_in = '0;
`endif

    // T6: three back-to-back windows, no bubble
    clear_got();
    c0 = cyc;
    for (int w = 0; w < 3; w++) send_n(TAPS, 8'(w + 1), 8'sd1);
    check("t6_cycles", cyc - c0, 108);
    drain();
    check_got("t6_w0", 0, 36, 1'b0);
    check_got("t6_w1", 1, 72, 1'b0);
    check_got("t6_w2", 2, 108, 1'b0);
    check("t6_count", got_q.size(), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
